// File: rtl/controller_pkg.sv
// Shared definitions for the NES controller serial reader: FSM state encoding
// and the bit position of each button in the published byte.
package controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_LOW    = 3'd2,
    ST_HIGH   = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  localparam logic [2:0] BTN_A      = 3'd0;
  localparam logic [2:0] BTN_B      = 3'd1;
  localparam logic [2:0] BTN_SELECT = 3'd2;
  localparam logic [2:0] BTN_START  = 3'd3;
  localparam logic [2:0] BTN_UP     = 3'd4;
  localparam logic [2:0] BTN_DOWN   = 3'd5;
  localparam logic [2:0] BTN_LEFT   = 3'd6;
  localparam logic [2:0] BTN_RIGHT  = 3'd7;

  localparam logic [2:0] LAST_BIT = BTN_RIGHT;

endpackage

// File: rtl/controller_shift_m.sv
// 8-bit LSB-first capture register for one controller. Each enabled cycle
// stores the inverted (active-high) serial line into the addressed bit.
module controller_shift_m
  import controller_pkg::*;
(
  input  logic       clk_1,
  input  logic       rst_B,
  input  logic       capture,
  input  logic [2:0] bit_idx,
  input  logic       data_in_B,
  output logic [7:0] shift_bits
);

  logic [7:0] shift_r;

  // Capture one serial bit into its button position
  always_ff @(posedge clk_1 or negedge rst_B) begin
    if (!rst_B) begin
      shift_r <= 8'h00;
    end else if (capture) begin
      shift_r[bit_idx] <= ~data_in_B;
    end
  end

  assign shift_bits = shift_r;

endmodule

// File: rtl/controller_reader.sv
// Serial front end for two NES-style controllers: latches both shift registers,
// clocks out 8 bits from each in parallel and publishes the bytes atomically.
module controller_reader
  import controller_pkg::*;
#(
  parameter int HALF_PERIOD = 6
) (
  input  logic       clk_1,
  input  logic       rst_B,
  input  logic       start,
  output logic       controller_latch,
  output logic       controller_clk,
  input  logic       controller_1_data_in_B,
  input  logic       controller_2_data_in_B,
  output logic [7:0] controller_1_buttons,
  output logic [7:0] controller_2_buttons,
  output logic       busy,
  output logic       done
);

  localparam int PW = $clog2(2 * HALF_PERIOD + 1);
  localparam logic [PW-1:0] LATCH_LOAD = PW'(2 * HALF_PERIOD - 1);
  localparam logic [PW-1:0] HALF_LOAD  = PW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0] PHASE_ONE  = PW'(1);

  state_e        state_r;
  state_e        next_state_s;
  logic [PW-1:0] phase_r;
  logic [PW-1:0] phase_next_s;
  logic [2:0]    bit_r;
  logic [2:0]    bit_next_s;
  logic          latch_r;
  logic          clk_r;
  logic          busy_r;
  logic          done_r;
  logic [7:0]    buttons_1_r;
  logic [7:0]    buttons_2_r;
  logic [7:0]    shift_1_s;
  logic [7:0]    shift_2_s;
  logic          phase_zero_s;
  logic          accept_s;
  logic          capture_s;

  assign phase_zero_s = (phase_r == '0);
  // done_r marks the visible commit cycle, during which a new start must be ignored
  assign accept_s     = (state_r == ST_IDLE) && start && !done_r;
  assign capture_s    = (state_r == ST_LOW) && phase_zero_s;

  // Next-state, phase and bit-counter decode
  always_comb begin
    next_state_s = state_r;
    phase_next_s = phase_r;
    bit_next_s   = bit_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = ST_LATCH;
          phase_next_s = LATCH_LOAD;
        end else begin
          phase_next_s = '0;
        end
      end
      ST_LATCH: begin
        if (phase_zero_s) begin
          next_state_s = ST_LOW;
          phase_next_s = HALF_LOAD;
          bit_next_s   = 3'd0;
        end else begin
          phase_next_s = phase_r - PHASE_ONE;
        end
      end
      ST_LOW: begin
        if (phase_zero_s) begin
          next_state_s = ST_HIGH;
          phase_next_s = HALF_LOAD;
        end else begin
          phase_next_s = phase_r - PHASE_ONE;
        end
      end
      ST_HIGH: begin
        if (phase_zero_s) begin
          if (bit_r == LAST_BIT) begin
            next_state_s = ST_COMMIT;
            phase_next_s = '0;
          end else begin
            next_state_s = ST_LOW;
            phase_next_s = HALF_LOAD;
            bit_next_s   = bit_r + 3'd1;
          end
        end else begin
          phase_next_s = phase_r - PHASE_ONE;
        end
      end
      ST_COMMIT: begin
        next_state_s = ST_IDLE;
        phase_next_s = '0;
      end
      default: begin
        next_state_s = ST_IDLE;
        phase_next_s = '0;
        bit_next_s   = 3'd0;
      end
    endcase
  end

  // FSM and counter registers
  always_ff @(posedge clk_1 or negedge rst_B) begin
    if (!rst_B) begin
      state_r <= ST_IDLE;
      phase_r <= '0;
      bit_r   <= 3'd0;
    end else begin
      state_r <= next_state_s;
      phase_r <= phase_next_s;
      bit_r   <= bit_next_s;
    end
  end

  // Registered pin and status outputs, decoded from the state being entered
  always_ff @(posedge clk_1 or negedge rst_B) begin
    if (!rst_B) begin
      latch_r     <= 1'b0;
      clk_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      buttons_1_r <= 8'h00;
      buttons_2_r <= 8'h00;
    end else begin
      latch_r <= (next_state_s == ST_LATCH);
      clk_r   <= (next_state_s == ST_HIGH);
      busy_r  <= (next_state_s != ST_IDLE) || (state_r == ST_COMMIT);
      done_r  <= (state_r == ST_COMMIT);
      if (state_r == ST_COMMIT) begin
        buttons_1_r <= shift_1_s;
        buttons_2_r <= shift_2_s;
      end
    end
  end

  controller_shift_m u_shift_1 (
    .clk_1      (clk_1),
    .rst_B      (rst_B),
    .capture    (capture_s),
    .bit_idx    (bit_r),
    .data_in_B  (controller_1_data_in_B),
    .shift_bits (shift_1_s)
  );

  controller_shift_m u_shift_2 (
    .clk_1      (clk_1),
    .rst_B      (rst_B),
    .capture    (capture_s),
    .bit_idx    (bit_r),
    .data_in_B  (controller_2_data_in_B),
    .shift_bits (shift_2_s)
  );

  assign controller_latch     = latch_r;
  assign controller_clk       = clk_r;
  assign busy                 = busy_r;
  assign done                 = done_r;
  assign controller_1_buttons = buttons_1_r;
  assign controller_2_buttons = buttons_2_r;

endmodule

// File: tb/tb_controller_reader.sv
// Bench for controller_reader: HALF_PERIOD=2 instance driven by two controller
// shift-register models with a scoreboard, plus a HALF_PERIOD=1 instance.
module tb_controller_reader;

  logic       clk_1 = 1'b0;
  logic       rst_n = 1'b1;
  int         cyc   = 0;
  int         chk_cnt  = 0;
  int         pass_cnt = 0;

  // Instance A (HALF_PERIOD=2)
  logic       start_a = 1'b0;
  logic       latch_a, ck_a, busy_a, done_a;
  logic       d1_a, d2_a;
  logic [7:0] b1_a, b2_a;
  // Instance B (HALF_PERIOD=1), all buttons pressed
  logic       start_b = 1'b0;
  logic       latch_b, ck_b, busy_b, done_b;
  logic       d1_b = 1'b0;
  logic       d2_b = 1'b0;
  logic [7:0] b1_b, b2_b;

  // Controller models for instance A
  logic [7:0] m1_val = 8'h00;
  logic [7:0] m2_val = 8'h00;
  logic [7:0] sr1 = 8'h00;
  logic [7:0] sr2 = 8'h00;
  logic       mprev = 1'b0;

  typedef struct packed {
    logic [7:0] b1;
    logic [7:0] b2;
    int         cyc;
  } exp_t;
  exp_t sb_q[$];

  int         edges_a = 0;
  int         latch_len_a = 0;
  int         done_cnt_a = 0;
  logic       prev_ck_a = 1'b0;
  logic       post_done_a = 1'b0;
  logic [7:0] held1 = 8'h00;
  logic [7:0] held2 = 8'h00;

  controller_reader #(.HALF_PERIOD(2)) dut_a (
    .clk_1                  (clk_1),
    .rst_B                  (rst_n),
    .start                  (start_a),
    .controller_latch       (latch_a),
    .controller_clk         (ck_a),
    .controller_1_data_in_B (d1_a),
    .controller_2_data_in_B (d2_a),
    .controller_1_buttons   (b1_a),
    .controller_2_buttons   (b2_a),
    .busy                   (busy_a),
    .done                   (done_a)
  );

  controller_reader #(.HALF_PERIOD(1)) dut_b (
    .clk_1                  (clk_1),
    .rst_B                  (rst_n),
    .start                  (start_b),
    .controller_latch       (latch_b),
    .controller_clk         (ck_b),
    .controller_1_data_in_B (d1_b),
    .controller_2_data_in_B (d2_b),
    .controller_1_buttons   (b1_b),
    .controller_2_buttons   (b2_b),
    .busy                   (busy_b),
    .done                   (done_b)
  );

  always #5 clk_1 = ~clk_1;

  // Cycle counter
  always @(posedge clk_1) cyc <= cyc + 1;

  // Controller 4021-style model: parallel load while latched, shift on clk rise
  always @(posedge clk_1) begin
    if (latch_a) begin
      sr1 <= m1_val;
      sr2 <= m2_val;
    end else if (ck_a && !mprev) begin
      sr1 <= {1'b0, sr1[7:1]};
      sr2 <= {1'b0, sr2[7:1]};
    end
    mprev <= ck_a;
  end
  assign d1_a = ~sr1[0];
  assign d2_a = ~sr2[0];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    else pass_cnt++;
  endtask

  // Scoreboard monitor for instance A
  always @(negedge clk_1) begin
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
      edges_a     = 0;
      latch_len_a = 0;
      prev_ck_a   = 1'b0;
      post_done_a = 1'b0;
      held1       = 8'h00;
      held2       = 8'h00;
    end else begin
      if (post_done_a) begin
        check_val("busy_after_done", {31'd0, busy_a}, 32'd0);
        post_done_a = 1'b0;
      end
      if (ck_a && !prev_ck_a) edges_a++;
      prev_ck_a = ck_a;
      if (latch_a) latch_len_a++;
      if (done_a) begin
        if (sb_q.size() == 0) begin
          check_val("spurious_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_val("latency", cyc - e.cyc, 32'd37);
          check_val("buttons_1", {24'd0, b1_a}, {24'd0, e.b1});
          check_val("buttons_2", {24'd0, b2_a}, {24'd0, e.b2});
          check_val("clk_edges", edges_a, 32'd8);
          check_val("latch_width", latch_len_a, 32'd4);
          check_val("busy_at_done", {31'd0, busy_a}, 32'd1);
          held1 = e.b1;
          held2 = e.b2;
        end
        edges_a     = 0;
        latch_len_a = 0;
        post_done_a = 1'b1;
        done_cnt_a++;
      end else begin
        check_val("hold_1", {24'd0, b1_a}, {24'd0, held1});
        check_val("hold_2", {24'd0, b2_a}, {24'd0, held2});
      end
    end
  end

  task automatic start_pulse_a(input logic accepted);
    @(negedge clk_1);
    start_a = 1'b1;
    @(negedge clk_1);
    start_a = 1'b0;
    if (accepted) sb_q.push_back('{b1: m1_val, b2: m2_val, cyc: cyc});
  endtask

  task automatic wait_done_a();
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_1);
      if (done_a) seen = 1'b1;
    end
    if (!seen) check_val("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_phase_a(input int n, input logic lvl);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_1);
      if (edges_a == n && ck_a == lvl) seen = 1'b1;
    end
    if (!seen) check_val("phase_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic any_act;
    int   sc, edges_b, latch_len_b;
    logic prev_b;
    bit   seen;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk_1);
    check_val("rst_latch", {31'd0, latch_a}, 32'd0);
    check_val("rst_clk", {31'd0, ck_a}, 32'd0);
    check_val("rst_busy", {31'd0, busy_a}, 32'd0);
    check_val("rst_done", {31'd0, done_a}, 32'd0);
    check_val("rst_buttons", {16'd0, b1_a, b2_a}, 32'd0);
    rst_n = 1'b1;

    // Idle with no start
    any_act = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_1);
      any_act = any_act | latch_a | ck_a | busy_a | done_a | latch_b | ck_b | busy_b | done_b;
    end
    check_val("idle_quiet", {31'd0, any_act}, 32'd0);

    // First read
    m1_val = 8'hA5; m2_val = 8'h3C;
    start_pulse_a(1'b1);
    check_val("busy_after_start", {31'd0, busy_a}, 32'd1);
    wait_done_a();
    repeat (3) @(negedge clk_1);

    // Second read, new data; outputs must hold until done
    m1_val = 8'h01; m2_val = 8'h80;
    start_pulse_a(1'b1);
    wait_done_a();
    repeat (3) @(negedge clk_1);

    // Starts during HIGH of bit 3 and on the done cycle are ignored
    m1_val = 8'h5A; m2_val = 8'h66;
    start_pulse_a(1'b1);
    wait_phase_a(4, 1'b1);
    start_pulse_a(1'b0);
    wait_done_a();
    start_a = 1'b1;
    @(negedge clk_1);
    start_a = 1'b0;
    repeat (60) @(negedge clk_1);
    check_val("done_count", done_cnt_a, 32'd3);
    check_val("idle_after_ignored", {31'd0, busy_a}, 32'd0);
    m1_val = 8'h0F; m2_val = 8'hF0;
    start_pulse_a(1'b1);
    wait_done_a();
    repeat (3) @(negedge clk_1);

    // Reset during LOW of bit 5
    m1_val = 8'hC3; m2_val = 8'h99;
    start_pulse_a(1'b1);
    wait_phase_a(5, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_val("abort_latch", {31'd0, latch_a}, 32'd0);
    check_val("abort_clk", {31'd0, ck_a}, 32'd0);
    check_val("abort_busy", {31'd0, busy_a}, 32'd0);
    check_val("abort_buttons", {16'd0, b1_a, b2_a}, 32'd0);
    repeat (3) @(negedge clk_1);
    rst_n = 1'b1;
    m1_val = 8'h96; m2_val = 8'h69;
    start_pulse_a(1'b1);
    wait_done_a();
    repeat (3) @(negedge clk_1);
    check_val("final_done_count", done_cnt_a, 32'd5);

    // HALF_PERIOD=1 with all buttons pressed
    @(negedge clk_1);
    start_b = 1'b1;
    @(negedge clk_1);
    start_b = 1'b0;
    sc = cyc;
    edges_b = 0;
    latch_len_b = 0;
    prev_b = ck_b;
    seen = 1'b0;
    if (latch_b) latch_len_b++;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk_1);
      if (ck_b && !prev_b) edges_b++;
      prev_b = ck_b;
      if (latch_b) latch_len_b++;
      if (done_b) seen = 1'b1;
    end
    if (!seen) check_val("b_done_timeout", 32'd0, 32'd1);
    check_val("b_latency", cyc - sc, 32'd19);
    check_val("b_buttons", {16'd0, b1_b, b2_b}, 32'h0000FFFF);
    check_val("b_clk_edges", edges_b, 32'd8);
    check_val("b_latch_width", latch_len_b, 32'd2);
    @(negedge clk_1);
    check_val("b_busy_after", {31'd0, busy_b}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
